mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB register. It steers store data onto byte lanes and checks alignment. It runs a request/ready handshake with a variable-latency data RAM and stalls the pipeline while the access is outstanding. It delivers the raw 32-bit read word as `readDataM`, which the WB stage later extends using `loadsrcW` and `aluresultW[1:0]`.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before the access is aborted with a bus error; legal range 2..255.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset; asynchronous assert, active-high.
- `memreadM`  in  1  load in MEM stage.
- `memwriteM`  in  1  store in MEM stage; never asserted together with `memreadM`.
- `sizeM`  in  3  funct3 of the load/store: 000 B, 001 H, 010 W, 100 BU, 101 HU; alignment uses bits [1:0].
- `aluresultM`  in  32  byte address.
- `writedataM`  in  32  store data, right-aligned.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  30  word address, `aluresultM[31:2]`.
- `dmem_wdata`  out  32  lane-steered store data.
- `dmem_wstrb`  out  4  byte strobes; 0000 on reads.
- `dmem_ready`  in  1  RAM completion for the current request.
- `dmem_rdata`  in  32  read word; valid when `dmem_ready`=1.
- `readDataM`  out  32  read word to MEM/WB.
- `stallM`  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- `misalignM`  out  1  misaligned access detected; no RAM request is issued.
- `buserrM`  out  1  access aborted by timeout.

## Operation
- `acc` = `memreadM | memwriteM`.
- `mis` = (`sizeM[1:0]`=01 & `addr[0]`) | (`sizeM[1:0]`=10 & `addr[1:0]`≠00). Sizes 011 and 11x are treated as W.
- Store steering:
  - B: wdata = {4{wd[7:0]}}, wstrb = 0001 << `addr[1:0]`.
  - H: wdata = {2{wd[15:0]}}, wstrb = `addr[1]` ? 1100 : 0011.
  - W: wdata = wd, wstrb = 1111.
- FSM states:
  - IDLE:
    - If `acc & mis`: `misalignM`=1 for the cycle, no request, `stallM`=0, stay in IDLE.
    - If `acc & ~mis`: `dmem_req`=1 combinationally. With `dmem_ready`=1 the access is zero-wait: `stallM`=0 and `readDataM`=`dmem_rdata`. Otherwise `stallM`=1 → WAIT, with the counter cleared to 1.
  - WAIT:
    - `dmem_req`=1 and address/data/strobes are held stable; `stallM`=1.
    - On `dmem_ready`: `stallM`=0, `readDataM`=`dmem_rdata`, → IDLE.
    - Else, when the counter = `TIMEOUT`: `dmem_req`=0, `buserrM`=1, `stallM`=0, `readDataM`=0, → IDLE.
    - Otherwise the counter increments.
- A store that times out is treated as not performed.
- `readDataM`=0 whenever no completing load is present; stores also drive 0.
- `dmem_ready` while `dmem_req`=0 is ignored.
- This block is the only source of stalls on EX/MEM; EX/MEM inputs are therefore stable for the whole access.

## Timing
- Reset values: state IDLE, counter 0. Outputs are then combinationally 0 except `dmem_addr` and `dmem_wdata`, which follow their inputs.
- Reset asserted mid-WAIT: `dmem_req` drops immediately (asynchronous), with no error flag.
- Zero-wait access: completes in the same cycle; 1 cycle in MEM.
- N-wait access: `stallM` is high for N cycles and the data is captured on the edge ending the ready cycle.
- Timeout: `stallM` is high for `TIMEOUT` cycles, then `buserrM` pulses for exactly 1 cycle.
- `misalignM` and `buserrM` are single-cycle pulses and are never asserted together.
- Back-to-back accesses: the cycle after completion can issue a new request with no idle bubble.

## Structure
- Package `riscv_mem_pkg`:
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`/`SZ_BU`/`SZ_HU`;
  - state enum {`S_IDLE`, `S_WAIT`};
  - counter width, $clog2(256).
- Sub-module `mem_store_align`: combinational block taking address low bits, size and store data; producing wdata, wstrb and the misalign flag.
- The FSM and counter live in the top level.

## Test plan
- SW 0xDEADBEEF @0x100 with `dmem_ready` tied high → `dmem_wstrb`=1111, wdata=0xDEADBEEF, `stallM` never asserted.
- SB 0x000000AB @0x203 → wstrb=1000, wdata=0xABABABAB; SH 0x1234 @0x202 → wstrb=1100, wdata=0x12341234.
- LW @0x40 with ready after 3 cycles and rdata=0xCAFEF00D → `stallM` high 3 cycles, `readDataM`=0xCAFEF00D in the ready cycle, inputs stable throughout.
- LH @0x41 → `misalignM` pulse, `dmem_req`=0, `stallM`=0; LW @0x42 gives the same result.
- `TIMEOUT`=4 and ready never asserted → `stallM` high 4 cycles, then `buserrM` for 1 cycle, `readDataM`=0, return to IDLE.
- `rst` pulsed during WAIT → `dmem_req` and `stallM` drop asynchronously; the next load after reset completes normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory-stage access path.
package riscv_mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int CNT_W = $clog2(256);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/mem_store_align.sv
// Byte-lane steering for stores plus the natural-alignment check.
module mem_store_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wd,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        mis
);

  // Signedness bit (BU/HU) does not affect lanes or alignment.
  logic size_unused;
  assign size_unused = size[2];

  always_comb begin
    wdata = wd;
    wstrb = 4'b1111;
    mis   = (addr_lo != 2'b00);
    case (size[1:0])
      SZ_B[1:0]: begin
        wdata = {4{wd[7:0]}};
        wstrb = 4'b0001 << addr_lo;
        mis   = 1'b0;
      end
      SZ_H[1:0]: begin
        wdata = {2{wd[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        mis   = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: handshakes with a variable-latency data RAM,
// stalls the pipeline while an access is outstanding, aborts on timeout.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  sizeM,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        buserrM
);

  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        acc;
  logic        mis;
  logic [3:0]  lane_strb;
  logic        done;

  assign acc       = memreadM | memwriteM;
  assign dmem_addr = aluresultM[31:2];

  mem_store_align u_align (
    .addr_lo (aluresultM[1:0]),
    .size    (sizeM),
    .wd      (writedataM),
    .wdata   (dmem_wdata),
    .wstrb   (lane_strb),
    .mis     (mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (acc && !mis && !dmem_ready) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready || (cnt_q == TO_C)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // rst gates outputs so a reset mid-access withdraws the request at once,
  // even though EX/MEM still presents the access.
  always_comb begin
    dmem_req  = 1'b0;
    stallM    = 1'b0;
    misalignM = 1'b0;
    buserrM   = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (acc && mis) begin
            misalignM = 1'b1;
          end else if (acc) begin
            dmem_req = 1'b1;
            done     = dmem_ready;
            stallM   = !dmem_ready;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            dmem_req = 1'b1;
            done     = 1'b1;
          end else if (cnt_q == TO_C) begin
            buserrM = 1'b1;
          end else begin
            dmem_req = 1'b1;
            stallM   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_we    = dmem_req & memwriteM;
  assign dmem_wstrb = dmem_we ? lane_strb : 4'b0000;
  assign readDataM  = (done && memreadM) ? dmem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, random transactions vs a
// transaction-level model, and hand-written reset sequences.
module tb_mem_access_unit;
  import riscv_mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [2:0]  sizeM;
  logic [31:0] aluresultM, writedataM;
  logic        dmem_req, dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] readDataM;
  logic        stallM, misalignM, buserrM;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM),
    .aluresultM(aluresultM), .writedataM(writedataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .readDataM(readDataM), .stallM(stallM),
    .misalignM(misalignM), .buserrM(buserrM)
  );

  always #5 clk = ~clk;

  // kind: 0 completes, 1 misaligned, 2 bus error, 3 no access
  typedef struct {
    logic        rd, wr;
    logic [2:0]  sz;
    logic [31:0] addr, wd, rdata;
    int          lat;
    logic [3:0]  strb;
    logic [31:0] wdat;
    int          stl;
    int          kind;
    logic [31:0] rdm;
  } txn_t;

  function automatic txn_t mk(logic rd, logic wr, logic [2:0] sz, logic [31:0] addr,
                              logic [31:0] wd, int lat, logic [31:0] rdata,
                              logic [3:0] strb, logic [31:0] wdat, int stl,
                              int kind, logic [31:0] rdm);
    txn_t t;
    t.rd = rd; t.wr = wr; t.sz = sz; t.addr = addr; t.wd = wd; t.lat = lat;
    t.rdata = rdata; t.strb = strb; t.wdat = wdat; t.stl = stl; t.kind = kind;
    t.rdm = rdm;
    return t;
  endfunction

  // Transaction-level reference: access width in bytes, lane replication by
  // multiplication, alignment by modulo, outcome from latency vs timeout.
  function automatic txn_t model(txn_t t);
    txn_t m;
    int   a;
    int   n;
    m = t;
    a = int'(t.addr[1:0]);
    n = (t.sz[1:0] == 2'b00) ? 1 : (t.sz[1:0] == 2'b01) ? 2 : 4;
    if (n == 1)      m.wdat = {24'b0, t.wd[7:0]} * 32'h01010101;
    else if (n == 2) m.wdat = {16'b0, t.wd[15:0]} * 32'h00010001;
    else             m.wdat = t.wd;
    m.strb = 4'(((1 << n) - 1) << a);
    m.rdm  = 32'h0;
    if (!(t.rd || t.wr)) begin
      m.kind = 3; m.stl = 0;
    end else if ((a % n) != 0) begin
      m.kind = 1; m.stl = 0;
    end else if (t.lat <= TO) begin
      m.kind = 0; m.stl = t.lat;
      if (t.rd) m.rdm = t.rdata;
    end else begin
      m.kind = 2; m.stl = TO;
    end
    return m;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [102:0] got,
                     input logic [102:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [102:0] outs();
    return {dmem_req, dmem_we, stallM, misalignM, buserrM, dmem_wstrb,
            readDataM, dmem_addr, dmem_wdata};
  endfunction

  task automatic drive(input txn_t t, input int i);
    memreadM   = t.rd;
    memwriteM  = t.wr;
    sizeM      = t.sz;
    aluresultM = t.addr;
    writedataM = t.wd;
    dmem_ready = (i == t.lat);
    dmem_rdata = (i == t.lat) ? t.rdata : $urandom;
  endtask

  task automatic run(input string nm, input txn_t t);
    logic e_req, e_we;
    for (int i = 0; i <= t.stl; i++) begin
      @(negedge clk);
      drive(t, i);
      #1;
      e_req = (t.kind == 0) || (t.kind == 2 && i < t.stl);
      e_we  = e_req && t.wr;
      chk(nm, i, outs(),
          {e_req, e_we, (i < t.stl), (t.kind == 1), (t.kind == 2 && i == t.stl),
           (e_we ? t.strb : 4'b0000), ((i == t.stl) ? t.rdm : 32'h0),
           t.addr[31:2], t.wdat});
    end
  endtask

  txn_t tbl [14];
  txn_t r;
  int   op;

  initial begin
    tbl[0]  = mk(0, 1, SZ_W,   32'h100, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, SZ_B,   32'h203, 32'h000000AB, 0, 32'h0,        4'h8, 32'hABABABAB, 0, 0, 32'h0);
    tbl[2]  = mk(0, 1, SZ_H,   32'h202, 32'h00001234, 0, 32'h0,        4'hC, 32'h12341234, 0, 0, 32'h0);
    tbl[3]  = mk(1, 0, SZ_W,   32'h040, 32'h0,        3, 32'hCAFEF00D, 4'hF, 32'h0,        3, 0, 32'hCAFEF00D);
    tbl[4]  = mk(1, 0, SZ_H,   32'h041, 32'h0,        0, 32'h11111111, 4'h0, 32'h0,        0, 1, 32'h0);
    tbl[5]  = mk(1, 0, SZ_W,   32'h042, 32'h0,        0, 32'h22222222, 4'h0, 32'h0,        0, 1, 32'h0);
    tbl[6]  = mk(1, 0, SZ_W,   32'h080, 32'h0,        9, 32'h55,       4'hF, 32'h0,        4, 2, 32'h0);
    tbl[7]  = mk(1, 0, SZ_BU,  32'h013, 32'h0,        4, 32'h11223344, 4'h8, 32'h0,        4, 0, 32'h11223344);
    tbl[8]  = mk(0, 1, SZ_B,   32'h001, 32'h0000005A, 2, 32'h0,        4'h2, 32'h5A5A5A5A, 2, 0, 32'h0);
    tbl[9]  = mk(0, 0, SZ_W,   32'h010, 32'h00000077, 0, 32'h99,       4'hF, 32'h00000077, 0, 3, 32'h0);
    tbl[10] = mk(0, 1, 3'b011, 32'h002, 32'h00000009, 0, 32'h0,        4'h0, 32'h00000009, 0, 1, 32'h0);
    tbl[11] = mk(0, 1, SZ_H,   32'h003, 32'h0000BEEF, 1, 32'h0,        4'h0, 32'hBEEFBEEF, 0, 1, 32'h0);
    tbl[12] = mk(0, 1, SZ_H,   32'h000, 32'h0000F00D, 7, 32'h0,        4'h3, 32'hF00DF00D, 4, 2, 32'h0);
    tbl[13] = mk(1, 0, SZ_HU,  32'h022, 32'h0,        1, 32'h87654321, 4'hC, 32'h0,        1, 0, 32'h87654321);

    // Reset state: request withheld even with a load presented.
    rst = 1'b1;
    drive(mk(1, 0, SZ_W, 32'h44, 32'h13579BDF, 0, 32'hFFFF, 0, 0, 0, 0, 0), 0);
    #1;
    chk("reset", 0, outs(),
        {5'b0, 4'b0000, 32'h0, 30'h11, 32'h13579BDF});
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) run($sformatf("tbl%0d", k), tbl[k]);

    // Reset during WAIT: request and stall drop without a bus error.
    r = mk(1, 0, SZ_W, 32'h300, 32'h0, 100, 32'h0, 4'hF, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(r, i);
      #1;
      chk("pre_rst_wait", i, {101'b0, dmem_req, stallM}, {101'b0, 2'b11});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst", 2, {100'b0, dmem_req, stallM, buserrM}, 103'b0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", model(mk(1, 0, SZ_W, 32'h300, 32'h0, 1, 32'hA5A55A5A, 0, 0, 0, 0, 0)));

    for (int k = 0; k < 300; k++) begin
      op      = $urandom_range(0, 4);
      r.rd    = (op <= 1);
      r.wr    = (op == 2 || op == 3);
      r.sz    = 3'($urandom);
      r.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
      r.wd    = $urandom;
      r.rdata = $urandom;
      r.lat   = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 8) : $urandom_range(0, 4);
      run("rnd", model(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
